// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        idle   = 3'd0,
        start  = 3'd1,
        data   = 3'd2,
        parity = 3'd3,
        stop   = 3'd4
    } uart_rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

endpackage

// File: rtl/uart_rx_if.sv
// Line-side / host-side signal bundle for the UART receiver.
interface uart_rx_if;
    logic       rx;
    logic       s_tick;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;
    logic       parity_err;

    modport master (
        output rx, s_tick,
        input  rx_done_tick, dout, frame_err, parity_err
    );

    modport slave (
        input  rx, s_tick,
        output rx_done_tick, dout, frame_err, parity_err
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer; both flops preset to 1 so an idle line reads high out of reset.
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    // Double-register the asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// UART receive deserializer, 16x oversampled, LSB first.
// Optional even-parity check is enabled by defining UART_RX_PARITY_EN.
//
// state  | meaning
// idle   | waiting for rx_s low
// start  | counting to the middle of the start bit
// data   | sampling DBIT data bits at mid-bit
// parity | sampling the parity bit (UART_RX_PARITY_EN only)
// stop   | waiting SB_TICK ticks, then publishing the frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave rx_if
);
    logic           rx_s;
    uart_rx_state_t state_reg, state_next;
    logic [4:0]     s_reg, s_next;
    logic [2:0]     n_reg, n_next;
    logic [7:0]     b_reg, b_next;
    logic [7:0]     dout_reg, dout_next;
    logic           ferr_reg, ferr_next;
    logic           done_reg, done_next;
    logic [7:0]     data_aligned;
`ifdef UART_RX_PARITY_EN
    logic           p_reg, p_next;
    logic           perr_reg, perr_next;
`endif

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_if.rx),
        .q     (rx_s)
    );

    // Shift register fills from the MSB, so short frames sit in the top bits.
    assign data_aligned = b_reg >> (8 - DBIT);

    // State, counters, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= idle;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            dout_reg  <= '0;
            ferr_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            p_reg     <= 1'b0;
            perr_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            dout_reg  <= dout_next;
            ferr_reg  <= ferr_next;
            done_reg  <= done_next;
`ifdef UART_RX_PARITY_EN
            p_reg     <= p_next;
            perr_reg  <= perr_next;
`endif
        end
    end

    // Next-state and next-output logic; counters only move on s_tick.
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        dout_next  = dout_reg;
        ferr_next  = ferr_reg;
        done_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        p_next     = p_reg;
        perr_next  = perr_reg;
`endif
        case (state_reg)
            idle: begin
                if (!rx_s) begin
                    state_next = start;
                    s_next     = '0;
                end
            end
            start: begin
                if (rx_if.s_tick) begin
                    if (s_reg == 5'(MID_TICK)) begin
                        if (!rx_s) begin
                            s_next     = '0;
                            n_next     = '0;
                            state_next = data;
                        end else begin
                            state_next = idle;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            data: begin
                if (rx_if.s_tick) begin
                    if (s_reg == 5'(OVERSAMPLE - 1)) begin
                        s_next = '0;
                        b_next = {rx_s, b_reg[7:1]};
                        if (n_reg == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_next = parity;
`else
                            state_next = stop;
`endif
                        end else begin
                            n_next = n_reg + 3'd1;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            parity: begin
                if (rx_if.s_tick) begin
                    if (s_reg == 5'(OVERSAMPLE - 1)) begin
                        p_next     = rx_s;
                        s_next     = '0;
                        state_next = stop;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
`endif
            stop: begin
                if (rx_if.s_tick) begin
                    if (s_reg == 5'(SB_TICK - 1)) begin
                        state_next = idle;
                        dout_next  = data_aligned;
                        ferr_next  = ~rx_s;
                        done_next  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_next  = (^data_aligned) ^ p_reg;
`endif
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            default: state_next = idle;
        endcase
    end

    assign rx_if.dout         = dout_reg;
    assign rx_if.frame_err    = ferr_reg;
    assign rx_if.rx_done_tick = done_reg;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err   = perr_reg;
`else
    assign rx_if.parity_err   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: one DBIT=8 and one DBIT=5 instance,
// s_tick every 4 clk, frames driven at 64 clk per bit.
module tb_uart_rx;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         gap_bits;
        logic [7:0] exp_dout;
        logic       exp_ferr;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [1:0] tcnt;
    logic       tick;
    int         tests;
    int         failed;
    int         done8;
    int         done5;
    int         pushed8;
    int         pushed5;
    exp_t       q8[$];
    exp_t       q5[$];
    exp_t       e8;
    exp_t       e5;
    vec_t       vecs[5];

    uart_rx_if u8_if ();
    uart_rx_if u5_if ();

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut8 (
        .clk   (clk),
        .reset (reset),
        .rx_if (u8_if.slave)
    );

    uart_rx #(.DBIT(5), .SB_TICK(16)) dut5 (
        .clk   (clk),
        .reset (reset),
        .rx_if (u5_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) tcnt <= 2'd0;
        else       tcnt <= tcnt + 2'd1;
    end
    assign tick         = (tcnt == 2'd3);
    assign u8_if.s_tick = tick;
    assign u5_if.s_tick = tick;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard for the 8-bit receiver.
    always @(negedge clk) begin
        if (u8_if.rx_done_tick === 1'b1) begin
            done8++;
            if (q8.size() == 0) begin
                check("dut8 unexpected done", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                check("dut8 dout", {24'd0, u8_if.dout}, {24'd0, e8.d});
                check("dut8 frame_err", {31'd0, u8_if.frame_err}, {31'd0, e8.fe});
                check("dut8 parity_err", {31'd0, u8_if.parity_err}, {31'd0, e8.pe});
            end
        end
    end

    // Scoreboard for the 5-bit receiver.
    always @(negedge clk) begin
        if (u5_if.rx_done_tick === 1'b1) begin
            done5++;
            if (q5.size() == 0) begin
                check("dut5 unexpected done", 32'd1, 32'd0);
            end else begin
                e5 = q5.pop_front();
                check("dut5 dout", {24'd0, u5_if.dout}, {24'd0, e5.d});
                check("dut5 frame_err", {31'd0, u5_if.frame_err}, {31'd0, e5.fe});
                check("dut5 parity_err", {31'd0, u5_if.parity_err}, {31'd0, e5.pe});
            end
        end
    end

    task automatic set_rx(input int which, input logic v);
        if (which == 5) u5_if.rx = v;
        else            u8_if.rx = v;
    endtask

    task automatic hold_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A low stop bit is held only past its mid-point so the receiver sees
    // the line return high before the next start-bit check.
    task automatic send_frame(input int which, input logic [7:0] d, input int nbits,
                              input logic stop_bit, input logic par_bit);
        set_rx(which, 1'b0);
        hold_clks(64);
        for (int i = 0; i < nbits; i++) begin
            set_rx(which, d[i]);
            hold_clks(64);
        end
`ifdef UART_RX_PARITY_EN
        set_rx(which, par_bit);
        hold_clks(64);
`endif
        set_rx(which, stop_bit);
        if (stop_bit) begin
            hold_clks(64);
        end else begin
            hold_clks(40);
            set_rx(which, 1'b1);
            hold_clks(24);
        end
        set_rx(which, 1'b1);
    endtask

    task automatic push8(input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.d = d; e.fe = fe; e.pe = pe;
        q8.push_back(e);
        pushed8++;
    endtask

    task automatic push5(input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.d = d; e.fe = fe; e.pe = pe;
        q5.push_back(e);
        pushed5++;
    endtask

    initial begin
        int done_snap;
        tests   = 0;
        failed  = 0;
        done8   = 0;
        done5   = 0;
        pushed8 = 0;
        pushed5 = 0;
        reset   = 1'b1;
        u8_if.rx = 1'b1;
        u5_if.rx = 1'b1;

        vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, gap_bits: 1, exp_dout: 8'hA5, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'h3C, stop_bit: 1'b0, gap_bits: 1, exp_dout: 8'h3C, exp_ferr: 1'b1};
        vecs[2] = '{data: 8'h81, stop_bit: 1'b1, gap_bits: 1, exp_dout: 8'h81, exp_ferr: 1'b0};
        vecs[3] = '{data: 8'h00, stop_bit: 1'b1, gap_bits: 0, exp_dout: 8'h00, exp_ferr: 1'b0};
        vecs[4] = '{data: 8'hFF, stop_bit: 1'b1, gap_bits: 1, exp_dout: 8'hFF, exp_ferr: 1'b0};

        hold_clks(3);
        check("reset dout", {24'd0, u8_if.dout}, 32'd0);
        check("reset frame_err", {31'd0, u8_if.frame_err}, 32'd0);
        check("reset parity_err", {31'd0, u8_if.parity_err}, 32'd0);
        check("reset done", {31'd0, u8_if.rx_done_tick}, 32'd0);
        reset = 1'b0;
        hold_clks(64);

        for (int i = 0; i < 5; i++) begin
            push8(vecs[i].exp_dout, vecs[i].exp_ferr, 1'b0);
            send_frame(8, vecs[i].data, 8, vecs[i].stop_bit, ^vecs[i].data);
            hold_clks(64 * vecs[i].gap_bits);
        end

        // Three-tick glitch: no frame, dout unchanged.
        done_snap = done8;
        u8_if.rx = 1'b0;
        hold_clks(12);
        u8_if.rx = 1'b1;
        hold_clks(64 * 3);
        check("glitch done count", done8, done_snap);
        check("glitch dout held", {24'd0, u8_if.dout}, {24'd0, vecs[4].exp_dout});

        // Reset in the middle of data bit 3 of 0xC3.
        done_snap = done8;
        u8_if.rx = 1'b0;
        hold_clks(64);
        for (int i = 0; i < 3; i++) begin
            u8_if.rx = (i != 2);
            hold_clks(64);
        end
        u8_if.rx = 1'b0;
        hold_clks(32);
        reset = 1'b1;
        u8_if.rx = 1'b1;
        hold_clks(2);
        check("mid reset dout", {24'd0, u8_if.dout}, 32'd0);
        check("mid reset frame_err", {31'd0, u8_if.frame_err}, 32'd0);
        check("mid reset parity_err", {31'd0, u8_if.parity_err}, 32'd0);
        reset = 1'b0;
        hold_clks(64 * 12);
        check("mid reset done count", done8, done_snap);
        check("after reset dout", {24'd0, u8_if.dout}, 32'd0);
        push8(8'h5A, 1'b0, 1'b0);
        send_frame(8, 8'h5A, 8, 1'b1, ^8'h5A);
        hold_clks(64);

        // Five-bit receiver, back-to-back frames.
        push5(8'h15, 1'b0, 1'b0);
        send_frame(5, 8'h15, 5, 1'b1, ^8'h15);
        push5(8'h0A, 1'b0, 1'b0);
        send_frame(5, 8'h0A, 5, 1'b1, ^8'h0A);
        hold_clks(64);

`ifdef UART_RX_PARITY_EN
        push8(8'h07, 1'b0, 1'b1);
        send_frame(8, 8'h07, 8, 1'b1, 1'b0);
        hold_clks(64);
        push8(8'h07, 1'b0, 1'b0);
        send_frame(8, 8'h07, 8, 1'b1, 1'b1);
        hold_clks(64);
`endif

        hold_clks(128);
        check("dut8 queue drained", q8.size(), 32'd0);
        check("dut5 queue drained", q5.size(), 32'd0);
        check("dut8 done count", done8, pushed8);
        check("dut5 done count", done5, pushed5);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive deserializer that samples the asynchronous serial line `rx` using the shared 16x oversampling tick `s_tick` from the baud-rate generator. It recovers each frame: start bit, DBIT data bits sent LSB first, an optional parity bit, and a stop period. When the frame completes it presents the byte on `dout` with a one-clock `rx_done_tick` and a framing-error flag. It sits on the line side opposite the transmitter and feeds the receive FIFO / host interface.

## Interface
- `DBIT`, 8, number of data bits; legal range 5..8.
- `SB_TICK`, 16, number of `s_tick`s in the stop period; legal values 16, 24, 32 (1, 1.5, 2 stop bits).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line; asynchronous to `clk`; idles high.
- `s_tick`  in  1  one-clock strobe at 16x baud rate.
- `rx_done_tick`  out  1  one-clock strobe marking a completed frame.
- `dout`  out  8  received data, right-justified; bits above DBIT are 0; held until the next frame completes.
- `frame_err`  out  1  stop bit sampled low on the last frame; held with `dout`.
- `parity_err`  out  1  parity mismatch on the last frame; held with `dout`; tied 0 when parity is compiled out.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1.
- Registers:
  - `s_reg`: 5-bit tick counter.
  - `n_reg`: 3-bit bit counter.
  - `b_reg`: 8-bit shift register; shifts right and loads the new bit at the MSB.
- FSM states: `idle`, `start`, `data`, `parity`, `stop`. Counters advance only on `s_tick`.
- `idle`:
  - If `rx_s == 0`, go to `start` and set `s = 0`. This check does not wait for `s_tick`.
- `start`:
  - On `s_tick` with `s == 7` (middle of the start bit):
    - If `rx_s == 0`, set `s = 0`, `n = 0` and go to `data`.
    - Otherwise the low level was a glitch; return to `idle` with no output.
  - On other `s_tick`s, increment `s`.
- `data`:
  - On `s_tick` with `s == 15`:
    - Set `s = 0` and `b = {rx_s, b[7:1]}`.
    - If `n == DBIT-1`, go to `parity` when compiled in, otherwise to `stop`.
    - Otherwise increment `n`.
  - On other `s_tick`s, increment `s`.
- `parity`:
  - On `s_tick` with `s == 15`, capture `rx_s` as `p_bit`, set `s = 0` and go to `stop`.
- `stop`:
  - On `s_tick` with `s == SB_TICK-1`, sample `rx_s` and return to `idle`.
  - In the same clock, register the outputs:
    - `dout = b >> (8-DBIT)`
    - `frame_err = ~rx_s`
    - `parity_err = ^data ^ p_bit`
    - `rx_done_tick = 1`
- A break condition (line held low) is not detected specially. It yields repeated frames of `0x00` with `frame_err = 1`, for as long as the line stays low.
- `rx` transitions between sample points are ignored. Each bit is sampled only at its mid-bit point.

## Timing
- Reset values:
  - State `idle`, all counters 0, `b_reg` 0.
  - `dout = 0`, `rx_done_tick = 0`, `frame_err = 0`, `parity_err = 0`.
- A reset asserted mid-frame aborts the frame. No `rx_done_tick` is generated, and the outputs return to their reset values.
- Input latency: 2 `clk` from `rx` to `rx_s`.
- All outputs are registered. `rx_done_tick` is high for exactly one `clk`, in the cycle after the clock edge where the final stop `s_tick` is taken.
- `dout`, `frame_err` and `parity_err` change only in that same cycle.
- Frame length from the start-bit sample point: 16·DBIT (+16 with parity) + SB_TICK ticks. The FSM is back in `idle` at the middle of the stop bit.
- This permits back-to-back frames with no idle gap. A falling edge during the second half of the stop bit starts the next frame.
- If `s_tick` coincides with entry to `start`, that tick is not counted.

## Configuration
- `UART_RX_PARITY_EN`: when defined, the `parity` state is present and even parity is checked: `parity_err = 1` when the XOR of the data bits and `p_bit` is 1.
- When not defined, the `parity` state is absent, the FSM goes from `data` straight to `stop`, and `parity_err` is constant 0.

## Structure
- Package `uart_pkg`:
  - `uart_rx_state_t` enum (`idle`, `start`, `data`, `parity`, `stop`).
  - Constants `OVERSAMPLE = 16` and `MID_TICK = 7`.
- Sub-module `uart_sync2`: 2-flop synchronizer with an asynchronous preset to 1.
- FSM, datapath and output registers are in `uart_rx`.

## Test plan
- Bench setup: DBIT=8, SB_TICK=16, `s_tick` every 4 `clk`.
- Frame `0xA5` with stop bit 1 -> exactly one `rx_done_tick`; `dout = 0xA5`, `frame_err = 0`.
- `rx` low for 3 ticks, then high -> FSM returns to `idle`; no `rx_done_tick`; `dout` keeps its previous value.
- Frame `0x3C` with stop bit 0 -> `dout = 0x3C`, `frame_err = 1`. A following good frame `0x81` -> `dout = 0x81`, `frame_err = 0`.
- Frames `0x00` then `0xFF` sent back-to-back with no idle gap -> two `rx_done_tick`s carrying `0x00` and `0xFF`. Repeat with DBIT=5 and data `0x15` -> `dout = 0x15`.
- `reset` pulsed during data bit 3 -> all outputs return to 0 and no done strobe occurs. The next frame `0x5A` is received correctly.
- With `UART_RX_PARITY_EN`: data `0x07` with parity bit 0 -> `parity_err = 1`; with parity bit 1 -> `parity_err = 0`.
